// File: rtl/cache_req_master.sv
// CPU-side request initiator for the cache: FIFO-buffered load/store issue with response pulses.
// Optional watchdog enabled by defining CACHE_REQ_TIMEOUT_EN.
module cache_req_master #(
    parameter int unsigned address_size    = 32,
    parameter int unsigned c_line_size     = 32,
    parameter int unsigned FIFO_DEPTH_LOG2 = 2,
    parameter int unsigned TIMEOUT_CYCLES  = 255
) (
    input  logic                       clk_i,
    input  logic                       reset_n_i,
    input  logic                       req_valid_i,
    output logic                       req_ready_o,
    input  logic                       req_wr_i,
    input  logic [address_size-1:0]    req_addr_i,
    input  logic [c_line_size-1:0]     req_wdata_i,
    output logic [address_size-1:0]    c_address_o,
    output logic                       c_read_o,
    output logic                       c_wr_o,
    output logic [c_line_size-1:0]     c_write_data_o,
    input  logic                       c_busywait_i,
    input  logic [c_line_size-1:0]     c_data_i,
    output logic                       rsp_valid_o,
    output logic                       rsp_wr_o,
    output logic [c_line_size-1:0]     rsp_data_o,
    output logic [FIFO_DEPTH_LOG2:0]   pending_o,
    output logic                       timeout_err_o
);

    localparam int unsigned DEPTH   = 1 << FIFO_DEPTH_LOG2;
    localparam int unsigned ENTRY_W = 1 + address_size + c_line_size;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        ERR    = 2'd2
    } state_t;

    state_t                     state, state_nxt;
    logic [FIFO_DEPTH_LOG2-1:0] wr_ptr, rd_ptr;
    logic [FIFO_DEPTH_LOG2:0]   count;
    logic [ENTRY_W-1:0]         fifo_mem [DEPTH];
    logic [ENTRY_W-1:0]         head;
    logic                       push, pop, complete, issue_wr;

`ifdef CACHE_REQ_TIMEOUT_EN
    logic [7:0] wd_cnt;
    logic       err_q;
`endif

    assign req_ready_o = (count != (FIFO_DEPTH_LOG2+1)'(DEPTH));
    assign push        = req_valid_i && req_ready_o;
    assign pending_o   = count;
    assign head        = fifo_mem[rd_ptr];

    always_ff @(posedge clk_i) begin
        if (push) fifo_mem[wr_ptr] <= {req_wr_i, req_addr_i, req_wdata_i};
    end

    always_comb begin
        state_nxt = state;
        pop       = 1'b0;
        complete  = 1'b0;
        c_read_o  = 1'b0;
        c_wr_o    = 1'b0;
        case (state)
            IDLE: begin
                if (count != '0) begin
                    pop       = 1'b1;
                    state_nxt = ACCESS;
                end
            end
            ACCESS: begin
                c_read_o = !issue_wr;
                c_wr_o   = issue_wr;
                if (!c_busywait_i) begin
                    complete = 1'b1;
                    if (count != '0) pop = 1'b1;
                    else             state_nxt = IDLE;
                end
`ifdef CACHE_REQ_TIMEOUT_EN
                // 8-bit counter would reach TIMEOUT_CYCLES at this edge
                else if (wd_cnt == 8'(TIMEOUT_CYCLES - 1)) begin
                    state_nxt = ERR;
                end
`endif
            end
            default: state_nxt = state;
        endcase
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state          <= IDLE;
            wr_ptr         <= '0;
            rd_ptr         <= '0;
            count          <= '0;
            c_address_o    <= '0;
            c_write_data_o <= '0;
            issue_wr       <= 1'b0;
            rsp_valid_o    <= 1'b0;
            rsp_wr_o       <= 1'b0;
            rsp_data_o     <= '0;
        end else begin
            state <= state_nxt;
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            if (pop) begin
                issue_wr       <= head[ENTRY_W-1];
                c_address_o    <= head[c_line_size +: address_size];
                c_write_data_o <= head[c_line_size-1:0];
            end
            rsp_valid_o <= complete;
            if (complete) begin
                rsp_wr_o <= issue_wr;
                if (!issue_wr) rsp_data_o <= c_data_i;
            end
        end
    end

`ifdef CACHE_REQ_TIMEOUT_EN
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            wd_cnt <= '0;
            err_q  <= 1'b0;
        end else begin
            if (pop)                                 wd_cnt <= '0;
            else if (state == ACCESS && c_busywait_i) wd_cnt <= wd_cnt + 8'd1;
            if (state_nxt == ERR) err_q <= 1'b1;
        end
    end
    assign timeout_err_o = err_q;
`else
    assign timeout_err_o = 1'b0;
`endif

endmodule

// File: tb/tb_cache_req_master.sv
// Scoreboard bench for cache_req_master: directed loads/stores against a hand-driven cache model.
module tb_cache_req_master;

    logic        clk_i = 1'b0;
    logic        reset_n_i;
    logic        req_valid_i, req_ready_o, req_wr_i;
    logic [31:0] req_addr_i, req_wdata_i;
    logic [31:0] c_address_o, c_write_data_o, c_data_i;
    logic        c_read_o, c_wr_o, c_busywait_i;
    logic        rsp_valid_o, rsp_wr_o;
    logic [31:0] rsp_data_o;
    logic [2:0]  pending_o;
    logic        timeout_err_o;

    int total = 0;
    int bad   = 0;
    logic [32:0] sb [$];

    always #5 clk_i = ~clk_i;

    cache_req_master #(
        .address_size   (32),
        .c_line_size    (32),
        .FIFO_DEPTH_LOG2(2),
        .TIMEOUT_CYCLES (255)
    ) dut (
        .clk_i         (clk_i),
        .reset_n_i     (reset_n_i),
        .req_valid_i   (req_valid_i),
        .req_ready_o   (req_ready_o),
        .req_wr_i      (req_wr_i),
        .req_addr_i    (req_addr_i),
        .req_wdata_i   (req_wdata_i),
        .c_address_o   (c_address_o),
        .c_read_o      (c_read_o),
        .c_wr_o        (c_wr_o),
        .c_write_data_o(c_write_data_o),
        .c_busywait_i  (c_busywait_i),
        .c_data_i      (c_data_i),
        .rsp_valid_o   (rsp_valid_o),
        .rsp_wr_o      (rsp_wr_o),
        .rsp_data_o    (rsp_data_o),
        .pending_o     (pending_o),
        .timeout_err_o (timeout_err_o)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    // Monitor: every response pulse is matched against the oldest expected entry.
    always @(negedge clk_i) begin
        if (reset_n_i === 1'b1 && rsp_valid_o === 1'b1) begin
            total++;
            if (sb.size() == 0) begin
                bad++;
                $display("FAIL unexpected_rsp: got wr=%0b data=0x%0h expected none", rsp_wr_o, rsp_data_o);
            end else begin
                logic [32:0] e;
                e = sb.pop_front();
                if ({rsp_wr_o, rsp_data_o} !== e) begin
                    bad++;
                    $display("FAIL rsp: got wr=%0b data=0x%0h expected wr=%0b data=0x%0h",
                             rsp_wr_o, rsp_data_o, e[32], e[31:0]);
                end
            end
        end
    end

    logic [31:0] st_addr [4];
    logic [31:0] st_data [4];

    initial begin
        st_addr[0] = 32'h1A; st_addr[1] = 32'h1E; st_addr[2] = 32'h12; st_addr[3] = 32'h3A;
        st_data[0] = 32'h38; st_data[1] = 32'h3;  st_data[2] = 32'h5;  st_data[3] = 32'h3;

        reset_n_i = 1'b0; req_valid_i = 1'b0; req_wr_i = 1'b0;
        req_addr_i = '0; req_wdata_i = '0; c_busywait_i = 1'b0; c_data_i = '0;
        #23;
        chk("rst_read",    {63'd0, c_read_o}, 64'd0);
        chk("rst_wr",      {63'd0, c_wr_o}, 64'd0);
        chk("rst_addr",    {32'd0, c_address_o}, 64'd0);
        chk("rst_wdata",   {32'd0, c_write_data_o}, 64'd0);
        chk("rst_rspv",    {63'd0, rsp_valid_o}, 64'd0);
        chk("rst_rspwr",   {63'd0, rsp_wr_o}, 64'd0);
        chk("rst_rspdata", {32'd0, rsp_data_o}, 64'd0);
        chk("rst_ready",   {63'd0, req_ready_o}, 64'd1);
        chk("rst_pending", {61'd0, pending_o}, 64'd0);
        chk("rst_terr",    {63'd0, timeout_err_o}, 64'd0);
        step();
        reset_n_i = 1'b1;
        step();

        // Load hit
        c_busywait_i = 1'b0; c_data_i = 32'h11;
        req_valid_i = 1'b1; req_wr_i = 1'b0; req_addr_i = 32'h0E;
        sb.push_back({1'b0, 32'h11});
        step();
        req_valid_i = 1'b0;
        chk("hit_pending_after_push", {61'd0, pending_o}, 64'd1);
        chk("hit_no_strobe_yet", {63'd0, c_read_o}, 64'd0);
        step();
        chk("hit_read_strobe", {63'd0, c_read_o}, 64'd1);
        chk("hit_wr_strobe",   {63'd0, c_wr_o}, 64'd0);
        chk("hit_addr",        {32'd0, c_address_o}, 64'h0E);
        step();
        chk("hit_rsp_valid", {63'd0, rsp_valid_o}, 64'd1);
        chk("hit_idle_strobe", {63'd0, c_read_o}, 64'd0);
        step();
        chk("hit_rsp_pulse_end", {63'd0, rsp_valid_o}, 64'd0);

        // Load miss: busywait high for 8 ACCESS edges
        c_busywait_i = 1'b1; c_data_i = 32'h22;
        req_valid_i = 1'b1; req_wr_i = 1'b0; req_addr_i = 32'h16;
        sb.push_back({1'b0, 32'h22});
        step();
        req_valid_i = 1'b0;
        step();
        for (int i = 0; i < 8; i++) begin
            chk("miss_read_held", {63'd0, c_read_o}, 64'd1);
            chk("miss_addr_held", {32'd0, c_address_o}, 64'h16);
            chk("miss_no_rsp", {63'd0, rsp_valid_o}, 64'd0);
            step();
        end
        c_busywait_i = 1'b0;
        step();
        chk("miss_rsp_valid", {63'd0, rsp_valid_o}, 64'd1);
        step();
        chk("miss_rsp_end", {63'd0, rsp_valid_o}, 64'd0);

        // Full FIFO and back-to-back: a blocking load keeps ACCESS busy while 4 stores fill the FIFO
        c_busywait_i = 1'b1; c_data_i = 32'h33;
        req_valid_i = 1'b1; req_wr_i = 1'b0; req_addr_i = 32'h40; req_wdata_i = '0;
        sb.push_back({1'b0, 32'h33});
        step();
        for (int i = 0; i < 4; i++) begin
            req_wr_i = 1'b1; req_addr_i = st_addr[i]; req_wdata_i = st_data[i];
            sb.push_back({1'b1, 32'h33});
            step();
        end
        chk("full_pending", {61'd0, pending_o}, 64'd4);
        chk("full_ready",   {63'd0, req_ready_o}, 64'd0);
        req_addr_i = 32'h99; req_wdata_i = 32'hDEAD;
        step();
        req_valid_i = 1'b0;
        chk("full_refused_pending", {61'd0, pending_o}, 64'd4);
        chk("full_blocker_addr", {32'd0, c_address_o}, 64'h40);
        c_busywait_i = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step();
            chk("b2b_rsp_valid", {63'd0, rsp_valid_o}, 64'd1);
            chk("b2b_wr_strobe", {63'd0, c_wr_o}, 64'd1);
            chk("b2b_addr",      {32'd0, c_address_o}, {32'd0, st_addr[i]});
            chk("b2b_wdata",     {32'd0, c_write_data_o}, {32'd0, st_data[i]});
        end
        step();
        chk("b2b_last_rsp", {63'd0, rsp_valid_o}, 64'd1);
        chk("b2b_idle_wr",  {63'd0, c_wr_o}, 64'd0);
        chk("b2b_empty",    {61'd0, pending_o}, 64'd0);
        step();
        chk("b2b_rsp_end", {63'd0, rsp_valid_o}, 64'd0);

        // Reset mid-miss
        c_busywait_i = 1'b1;
        req_valid_i = 1'b1; req_wr_i = 1'b0; req_addr_i = 32'h50;
        step();
        req_addr_i = 32'h54;
        step();
        req_valid_i = 1'b0;
        chk("rmid_read_before", {63'd0, c_read_o}, 64'd1);
        chk("rmid_pending_before", {61'd0, pending_o}, 64'd1);
        #2 reset_n_i = 1'b0;
        #1;
        chk("rmid_read_drop", {63'd0, c_read_o}, 64'd0);
        chk("rmid_wr_drop",   {63'd0, c_wr_o}, 64'd0);
        chk("rmid_pending",   {61'd0, pending_o}, 64'd0);
        chk("rmid_addr",      {32'd0, c_address_o}, 64'd0);
        step();
        step();
        reset_n_i = 1'b1;
        c_busywait_i = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step();
            chk("rmid_no_strobe", {63'd0, c_read_o}, 64'd0);
        end

        // Watchdog: busywait stuck high
        c_busywait_i = 1'b1; c_data_i = 32'h77;
        req_valid_i = 1'b1; req_wr_i = 1'b0; req_addr_i = 32'h60;
        step();
        req_valid_i = 1'b0;
        step();
        for (int i = 0; i < 254; i++) step();
        chk("to_before_err", {63'd0, timeout_err_o}, 64'd0);
        chk("to_before_strobe", {63'd0, c_read_o}, 64'd1);
        step();
`ifdef CACHE_REQ_TIMEOUT_EN
        chk("to_err_set",    {63'd0, timeout_err_o}, 64'd1);
        chk("to_err_strobe", {63'd0, c_read_o}, 64'd0);
        c_busywait_i = 1'b0;
        for (int i = 0; i < 4; i++) step();
        chk("to_err_sticky", {63'd0, timeout_err_o}, 64'd1);
        chk("to_no_rsp", {63'd0, rsp_valid_o}, 64'd0);
`else
        chk("to_no_err",     {63'd0, timeout_err_o}, 64'd0);
        chk("to_strobe_held", {63'd0, c_read_o}, 64'd1);
        chk("to_addr_held",  {32'd0, c_address_o}, 64'h60);
        sb.push_back({1'b0, 32'h77});
        c_busywait_i = 1'b0;
        step();
        chk("to_late_rsp", {63'd0, rsp_valid_o}, 64'd1);
        for (int i = 0; i < 3; i++) step();
`endif
        chk("sb_drained", 64'(sb.size()), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/cache_req_master.md
# cache_req_master

CPU-side request initiator for the `cache` block. It accepts load/store requests from the pipeline into a small FIFO and drives the cache's `address`/`c_read_i`/`c_wr_i`/`c_write_data_i` inputs. It holds each request stable while the cache asserts `c_busywait_o`, and returns one response per request. It replaces hand-driven testbench stimulus and is the pipeline's only path into the cache.

## Interface
- `address_size`, 32: request address width.
- `c_line_size`, 32: data word width.
- `FIFO_DEPTH_LOG2`, 2: request FIFO depth is 2**FIFO_DEPTH_LOG2 (4 entries).
- `TIMEOUT_CYCLES`, 255: watchdog limit in cycles; 8-bit counter; only used with `CACHE_REQ_TIMEOUT_EN`.

Ports:
- `clk_i`  in  1  clock; all state updates on the rising edge.
- `reset_n_i`  in  1  asynchronous, active-low reset.
- `req_valid_i`  in  1  upstream request present.
- `req_ready_o`  out  1  FIFO not full.
- `req_wr_i`  in  1  1 = store, 0 = load.
- `req_addr_i`  in  address_size  request byte address.
- `req_wdata_i`  in  c_line_size  store data.
- `c_address_o`  out  address_size  to cache `address_i`.
- `c_read_o`  out  1  to cache `c_read_i`.
- `c_wr_o`  out  1  to cache `c_wr_i`.
- `c_write_data_o`  out  c_line_size  to cache write data.
- `c_busywait_i`  in  1  from cache `c_busywait_o`.
- `c_data_i`  in  c_line_size  from cache `c_data_o`.
- `rsp_valid_o`  out  1  one-cycle response pulse.
- `rsp_wr_o`  out  1  response belongs to a store.
- `rsp_data_o`  out  c_line_size  load data; holds its previous value for stores.
- `pending_o`  out  FIFO_DEPTH_LOG2+1  FIFO occupancy.
- `timeout_err_o`  out  1  sticky watchdog error.

## Operation
- FIFO: circular buffer with FIFO_DEPTH_LOG2-bit read/write pointers that wrap modulo depth, plus an occupancy counter.
  - A push happens when `req_valid_i && req_ready_o`.
  - `req_ready_o = (pending_o != depth)`. A pop in the same cycle does not free space for that cycle's push.
- FSM states:
  - IDLE:
    - Strobes are 0.
    - If the FIFO is non-empty, pop the head into the issue registers and go to ACCESS.
  - ACCESS:
    - `c_read_o = !wr`, `c_wr_o = wr`. Address and data are held from the issue registers and never change while in ACCESS.
    - Completion is any rising edge in ACCESS with `c_busywait_i == 0`.
    - On completion, load `rsp_data_o <= c_data_i` (loads only), pulse `rsp_valid_o` next cycle, and update `rsp_wr_o`.
    - Then, if the FIFO is non-empty, pop the next entry and stay in ACCESS (back-to-back); otherwise go to IDLE.
  - ERR (only with `CACHE_REQ_TIMEOUT_EN`):
    - Strobes are 0 and `timeout_err_o` is 1.
    - Leaves only on reset; no further pops.
- Simultaneous push and pop: occupancy is unchanged and both pointers advance.
- An empty FIFO in IDLE means no strobes are asserted.
- Reset at any time:
  - Pointers, occupancy, FSM state (IDLE), strobes, `rsp_valid_o`, `rsp_wr_o`, `rsp_data_o`, `c_address_o`, `c_write_data_o`, watchdog counter and `timeout_err_o` all go to 0.
  - An in-flight cache access is abandoned. Strobes drop immediately because reset is asynchronous.

## Timing
- Issue latency: a request pushed at edge N into an empty FIFO with the FSM in IDLE has strobes asserted after edge N+1.
- Hit with `c_busywait_i` low on the first cycle:
  - Completion at edge N+2, `rsp_valid_o` high after N+2 for one cycle.
  - Sustained throughput is one access per cycle.
- Miss: strobes and address stay stable for as long as `c_busywait_i` is high. Completion is the first edge at which it is sampled low.
- `c_busywait_i` is sampled only in ACCESS and ignored elsewhere.
- `rsp_valid_o` never stays high for two cycles for the same request. It is high on consecutive cycles only for back-to-back completions.

## Configuration
- `CACHE_REQ_TIMEOUT_EN`:
  - Defined: an 8-bit counter clears on entry to ACCESS and increments each ACCESS cycle with `c_busywait_i` high. When it reaches TIMEOUT_CYCLES, the FSM enters ERR, `timeout_err_o` is set, and no response is issued.
  - Undefined: no counter, ACCESS waits indefinitely, `timeout_err_o` is tied to 0.

## Test plan
- Reset: `reset_n_i` low -> all outputs 0, `req_ready_o` = 1, `pending_o` = 0.
- Load hit: push load 0x0000000E; cache model busywait 0, data 0x11 -> strobe `c_read_o` 1 cycle after the push edge, `rsp_valid_o` pulse with `rsp_data_o` = 0x11 and `rsp_wr_o` = 0.
- Load miss: push load 0x00000016; model holds busywait high 8 cycles, then returns 0x22 -> address stable for all 8 cycles, single response with data 0x22.
- Full/back-to-back:
  - Push 4 stores (addresses 0x1A, 0x1E, 0x12, 0x3A; data 0x38, 3, 5, 3) while busywait is high -> `req_ready_o` = 0 at `pending_o` = 4 and a 5th push is refused.
  - Release busywait -> 4 consecutive `rsp_valid_o` pulses, in order.
- Reset mid-miss: assert `reset_n_i` low during ACCESS -> `c_read_o`/`c_wr_o` drop without waiting for a clock edge, FIFO empty, no response.
- Timeout (macro defined): busywait stuck high -> `timeout_err_o` = 1 after 255 cycles, strobes 0, no `rsp_valid_o`. With the macro undefined, the same stimulus gives `timeout_err_o` = 0 and the strobe is held.
